// File: rtl/vdp18_scandoubler.sv
// vdp18_scandoubler: buffers one core line and replays it twice at the 10.7 MHz strobe
// clk_i, reset_n_i        : system clock, asynchronous active-low reset
// clk_en_10m7_i, ce_pix_i : output pixel strobe, input pixel strobe (every second output strobe)
// enable_i                : 1 = line doubling, 0 = core signals registered straight through
// col_i, *_n_i            : core colour index, hsync, vsync, blank
// col_o, *_n_o            : doubled (or bypassed) colour index, hsync, vsync, blank
// locked_o, line_len_o    : line length >= min_line_g, last measured input line length
module vdp18_scandoubler #(
   parameter int hs_width_g = 26,
   parameter int min_line_g = 16
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       clk_en_10m7_i,
   input  logic       ce_pix_i,
   input  logic       enable_i,
   input  logic [3:0] col_i,
   input  logic       hsync_n_i,
   input  logic       vsync_n_i,
   input  logic       blank_n_i,
   output logic [3:0] col_o,
   output logic       hsync_n_o,
   output logic       vsync_n_o,
   output logic       blank_n_o,
   output logic       locked_o,
   output logic [8:0] line_len_o
);
   // both banks live in one array; the top address bit is the bank
   logic [4:0] mem [1024];
   logic [4:0] rd_d;
   logic [8:0] wr_x, rd_x, line_len_q;
   logic       wr_bank, hs_prev, vs_line_q, h1, v1, hs_fall, unlocked;
   always_comb begin
      hs_fall  = ce_pix_i & ~hsync_n_i & hs_prev;
      unlocked = line_len_q < 9'(min_line_g);
   end
   always_ff @(posedge clk_i) begin
      if (ce_pix_i && !hs_fall) mem[{wr_bank, wr_x}] <= {blank_n_i, col_i};
      if (clk_en_10m7_i) rd_d <= mem[{~wr_bank, rd_x}];
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         wr_x       <= '0;
         line_len_q <= '0;
         wr_bank    <= 1'b0;
         hs_prev    <= 1'b1;
         vs_line_q  <= 1'b1;
      end else if (ce_pix_i) begin
         hs_prev <= hsync_n_i;
         if (hs_fall) begin
            line_len_q <= wr_x;
            wr_x       <= '0;
            wr_bank    <= ~wr_bank;
            vs_line_q  <= vsync_n_i;
         end else if (wr_x != 9'd511) wr_x <= wr_x + 9'd1;
      end
   // an input hsync fall restarts the replay even off-strobe, so both output lines track the input line
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         rd_x       <= '0;
         h1         <= 1'b0;
         v1         <= 1'b1;
         col_o      <= '0;
         hsync_n_o  <= 1'b1;
         vsync_n_o  <= 1'b1;
         blank_n_o  <= 1'b0;
         locked_o   <= 1'b0;
         line_len_o <= '0;
      end else begin
         locked_o   <= ~unlocked;
         line_len_o <= line_len_q;
         if (hs_fall || (clk_en_10m7_i && (unlocked || rd_x == line_len_q - 9'd1))) rd_x <= '0;
         else if (clk_en_10m7_i) rd_x <= rd_x + 9'd1;
         if (clk_en_10m7_i) begin
            h1 <= rd_x < 9'(hs_width_g);
            if (rd_x == '0) v1 <= vs_line_q;
         end
         if (!enable_i) begin
            col_o     <= col_i;
            hsync_n_o <= hsync_n_i;
            vsync_n_o <= vsync_n_i;
            blank_n_o <= blank_n_i;
         end else if (clk_en_10m7_i) begin
            col_o     <= unlocked ? 4'd0 : rd_d[3:0];
            blank_n_o <= ~unlocked & rd_d[4];
            hsync_n_o <= unlocked | ~h1;
            vsync_n_o <= unlocked | v1;
         end
      end
endmodule

// File: tb/tb_vdp18_scandoubler.sv
// tb_vdp18_scandoubler: directed checks of doubling, lock, saturation, vsync, bypass and reset
module tb_vdp18_scandoubler;
   logic       clk = 1'b0, reset_n = 1'b0, clk_en = 1'b0, ce_pix = 1'b0, enable = 1'b1;
   logic [3:0] col_i = '0;
   logic       hsync_n_i = 1'b1, vsync_n_i = 1'b1, blank_n_i = 1'b0;
   logic [3:0] col_o;
   logic       hsync_n_o, vsync_n_o, blank_n_o, locked;
   logic [8:0] line_len;
   logic [1:0] ph = '0;
   int         checks = 0, errors = 0, tn = 0;
   logic [6:0] tr [4096];
   logic       tr_f [4096];
   logic       rec = 1'b0, hp = 1'b1;
   vdp18_scandoubler dut (
      .clk_i(clk), .reset_n_i(reset_n), .clk_en_10m7_i(clk_en), .ce_pix_i(ce_pix),
      .enable_i(enable), .col_i(col_i), .hsync_n_i(hsync_n_i), .vsync_n_i(vsync_n_i),
      .blank_n_i(blank_n_i), .col_o(col_o), .hsync_n_o(hsync_n_o), .vsync_n_o(vsync_n_o),
      .blank_n_o(blank_n_o), .locked_o(locked), .line_len_o(line_len)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      ph = ph + 2'd1;
      clk_en = ph[0];
      ce_pix = ph == 2'd3;
   end
   // trace of outputs after every output strobe, tagged with input hsync falls seen at that edge
   always @(posedge clk) if (clk_en) begin
      logic f;
      f = ce_pix && !hsync_n_i && hp;
      if (ce_pix) hp = hsync_n_i;
      #2;
      if (rec && tn < 4096) begin
         tr[tn] = {col_o, hsync_n_o, vsync_n_o, blank_n_o};
         tr_f[tn] = f;
         tn++;
      end
   end
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic drv(input logic [3:0] c, input logic hs, input logic vs, input logic bl);
      {col_i, hsync_n_i, vsync_n_i, blank_n_i} = {c, hs, vs, bl};
      do @(posedge clk); while (!ce_pix);
      #1;
   endtask
   task automatic line(input int n, input int m, input logic vs);
      drv(4'd0, 1'b0, vs, 1'b0);
      for (int k = 0; k < n; k++) drv(4'(k % m), 1'b1, vs, 1'b1);
   endtask
   function automatic int nth_fall(input int n);
      int c = 0;
      for (int i = 0; i < tn; i++) if (tr_f[i]) begin
         if (c == n) return i;
         c++;
      end
      return -1000;
   endfunction
   function automatic logic [6:0] at(input int i);
      return (i >= 0 && i < tn) ? tr[i] : 7'bx;
   endfunction
   initial begin
      int a, e, fl;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_col", col_o, 0);
      chk("rst_hs", hsync_n_o, 1);
      chk("rst_vs", vsync_n_o, 1);
      chk("rst_bl", blank_n_o, 0);
      chk("rst_lock", locked, 0);
      chk("rst_len", line_len, 0);
      reset_n = 1'b1;
      tn = 0; rec = 1'b1;
      repeat (3) line(8, 16, 1'b1);
      repeat (4) drv(4'd0, 1'b1, 1'b1, 1'b1);
      rec = 1'b0;
      e = 0;
      for (int i = 0; i < tn; i++) if (tr[i][2] !== 1'b1 || tr[i][0] !== 1'b0 || tr[i][6:3] !== 4'd0) e++;
      chk("unl_out", e, 0);
      chk("unl_lock", locked, 0);
      chk("unl_len", line_len, 8);
      tn = 0; rec = 1'b1;
      repeat (4) line(342, 16, 1'b1);
      rec = 1'b0;
      chk("ramp_len", line_len, 342);
      chk("ramp_lock", locked, 1);
      a = nth_fall(1); e = 0;
      for (int k = 0; k < 684; k++)
         if (at(a + 2 + k) !== {4'((k % 342) % 16), 1'((k % 342) >= 26), 2'b11}) e++;
      chk("ramp_line", e, 0);
      tn = 0; rec = 1'b1;
      line(600, 13, 1'b1);
      line(20, 16, 1'b1);
      rec = 1'b0;
      chk("sat_len", line_len, 511);
      chk("sat_lock", locked, 1);
      a = nth_fall(1); e = 0;
      for (int k = 0; k < 30; k++) if (at(a + 2 + k) !== {4'(k % 13), 1'(k >= 26), 2'b11}) e++;
      chk("sat_data", e, 0);
      tn = 0; rec = 1'b1;
      repeat (2) line(20, 16, 1'b1);
      repeat (3) line(20, 16, 1'b0);
      repeat (3) line(20, 16, 1'b1);
      rec = 1'b0;
      a = nth_fall(2); e = 0; fl = -1;
      for (int i = 0; i < tn; i++) if (tr[i][1] === 1'b0) begin
         e++;
         if (fl < 0) fl = i;
      end
      chk("vs_len", e, 126);
      chk("vs_start", fl - a, 2);
      enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         logic [6:0] v;
         v = 7'($urandom);
         {col_i, hsync_n_i, vsync_n_i, blank_n_i} = v;
         @(posedge clk);
         #1;
         chk("bypass", {col_o, hsync_n_o, vsync_n_o, blank_n_o}, v);
      end
      enable = 1'b1;
      drv(4'd0, 1'b1, 1'b1, 1'b1);
      repeat (2) line(20, 16, 1'b1);
      repeat (5) drv(4'd3, 1'b1, 1'b1, 1'b1);
      chk("pre_lock", locked, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out", {col_o, hsync_n_o, vsync_n_o, blank_n_o}, 7'b0000110);
      chk("mid_rst_lock", locked, 0);
      chk("mid_rst_len", line_len, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      line(20, 16, 1'b1);
      chk("relock1", locked, 0);
      line(20, 16, 1'b1);
      chk("relock2", locked, 1);
      chk("relock_len", line_len, 20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
